// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if
//   Bundles the data and display signals of the BCD display scanner.
//   master : producer/observer side (drives digits and controls, reads display)
//   slave  : scanner side (reads digits and controls, drives display)
//   digits      16  {d3,d2,d1,d0}, d0 = tenths
//   dp_mask      4  decimal point enable per digit
//   lz_blank     1  leading-zero suppression enable
//   blank        1  force display dark (live)
//   an           4  anode selects, active-low
//   seg          7  segments {g,f,e,d,c,b,a}, active-low
//   dp           1  decimal point, active-low
//   frame_start  1  one-cycle pulse when a new snapshot is taken
interface bcd_display_scan_if;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lz_blank;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;

   modport master (
      output digits, dp_mask, lz_blank, blank,
      input  an, seg, dp, frame_start
   );

   modport slave (
      input  digits, dp_mask, lz_blank, blank,
      output an, seg, dp, frame_start
   );
endinterface

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Time-multiplexes four BCD digits onto a common-anode 4-digit seven-segment
//   display. Inputs are snapshotted once per frame so a counter rollover in
//   the middle of a scan never shows a torn value.
//   clk5   system clock
//   reset  synchronous, active-high
//   bus    bcd_display_scan_if.slave (digits/controls in, an/seg/dp/frame_start out)
module bcd_display_scan #(
   parameter int REFRESH_DIV = 20000,
   parameter int BLANK_CYC   = 16
) (
   input logic               clk5,
   input logic               reset,
   bcd_display_scan_if.slave bus
);

   localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

   // Seven-segment decode, gfedcba active-low; non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // A digit is a suppressible leading zero when it and every more significant
   // digit are zero and none of them carries a decimal point. Digit 0 always shows.
   function automatic logic lz_suppressed(input logic [1:0]  pos,
                                          input logic [15:0] dig,
                                          input logic [3:0]  mask,
                                          input logic        lz);
      logic sup;
      case (pos)
         2'd1:    sup = lz && (dig[15:4]  == 12'd0) && (mask[3:1] == 3'd0);
         2'd2:    sup = lz && (dig[15:8]  == 8'd0)  && (mask[3:2] == 2'd0);
         2'd3:    sup = lz && (dig[15:12] == 4'd0)  && (mask[3]   == 1'b0);
         default: sup = 1'b0;
      endcase
      return sup;
   endfunction

   logic [CW-1:0] cnt_r;
   logic [1:0]    idx_r;
   logic [15:0]   snap_digits_r;
   logic [3:0]    snap_mask_r;
   logic          snap_lz_r;
   logic [3:0]    an_r;
   logic [6:0]    seg_r;
   logic          dp_r;
   logic          frame_start_r;

   logic          tick_s;
   logic          frame_end_s;
   logic [3:0]    digit_s;
   logic          sup_s;
   logic          lit_s;
   logic [3:0]    an_s;
   logic [6:0]    seg_s;
   logic          dp_s;

   // Slot-end and frame-end strobes from the prescaler.
   always_comb begin
      tick_s      = (cnt_r == CNT_LAST);
      frame_end_s = tick_s && (idx_r == 2'd3);
   end

   // Prescaler and slot index; blank never disturbs the scan phase.
   always_ff @(posedge clk5) begin
      if (reset) begin
         cnt_r <= '0;
         idx_r <= 2'd0;
      end else if (tick_s) begin
         cnt_r <= '0;
         idx_r <= idx_r + 2'd1;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Per-frame snapshot of the inputs and the frame_start pulse.
   always_ff @(posedge clk5) begin
      if (reset) begin
         snap_digits_r <= 16'd0;
         snap_mask_r   <= 4'd0;
         snap_lz_r     <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (frame_end_s) begin
         snap_digits_r <= bus.digits;
         snap_mask_r   <= bus.dp_mask;
         snap_lz_r     <= bus.lz_blank;
         frame_start_r <= 1'b1;
      end else begin
         frame_start_r <= 1'b0;
      end
   end

   // Select the digit of the current slot from the snapshot.
   always_comb begin
      case (idx_r)
         2'd0:    digit_s = snap_digits_r[3:0];
         2'd1:    digit_s = snap_digits_r[7:4];
         2'd2:    digit_s = snap_digits_r[11:8];
         2'd3:    digit_s = snap_digits_r[15:12];
         default: digit_s = 4'd0;
      endcase
   end

   // Next display outputs: dark during blank or the anti-ghosting interval,
   // segments/dp dark for suppressed leading zeros while the anode still scans.
   always_comb begin
      an_s  = 4'b1111;
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
      sup_s = lz_suppressed(idx_r, snap_digits_r, snap_mask_r, snap_lz_r);
      lit_s = !bus.blank && (cnt_r >= CNT_BLANK);
      if (lit_s) begin
         an_s = ~(4'b0001 << idx_r);
         if (sup_s) begin
            seg_s = 7'b1111111;
            dp_s  = 1'b1;
         end else begin
            seg_s = seg_decode(digit_s);
            dp_s  = ~snap_mask_r[idx_r];
         end
      end else begin
         an_s  = 4'b1111;
         seg_s = 7'b1111111;
         dp_s  = 1'b1;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk5) begin
      if (reset) begin
         an_r  <= 4'b1111;
         seg_r <= 7'b1111111;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_s;
         seg_r <= seg_s;
         dp_r  <= dp_s;
      end
   end

   assign bus.an          = an_r;
   assign bus.seg         = seg_r;
   assign bus.dp          = dp_r;
   assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan
//   Self-checking bench for bcd_display_scan (REFRESH_DIV=8, BLANK_CYC=2).
//   A timeline model (cycles since reset -> slot/phase, frame boundaries)
//   predicts an/seg/dp/frame_start for every cycle of directed and random stimulus.
module tb_bcd_display_scan;

   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = 4 * DIV;

   logic clk5;
   logic reset;

   bcd_display_scan_if bus ();

   bcd_display_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
      .clk5  (clk5),
      .reset (reset),
      .bus   (bus)
   );

   initial clk5 = 1'b0;
   always #5 clk5 = ~clk5;

   int errors = 0;
   int checks = 0;

   // Model state
   int          t;
   logic [15:0] m_dig;
   logic [3:0]  m_mask;
   logic        m_lz;
   int          cyc;
   int          last_fs;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Predict the outputs of the coming edge, clock it, compare.
   task automatic step();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_fs;
      int         phase;
      int         slot;
      int         dv;
      bit         lit;
      bit         sup;
      if (reset) begin
         e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fs = 1'b0;
         t = 0; m_dig = 16'd0; m_mask = 4'd0; m_lz = 1'b0;
         last_fs = -1;
      end else begin
         phase = t % DIV;
         slot  = (t / DIV) % 4;
         lit   = !bus.blank && (phase >= BLK);
         dv    = int'((m_dig >> (4 * slot)) & 16'hF);
         sup   = m_lz && (slot > 0) && ((m_dig >> (4 * slot)) == 16'd0)
                 && ((m_mask >> slot) == 4'd0);
         e_an  = lit ? an_tab[slot] : 4'b1111;
         e_seg = (!lit || sup) ? 7'b1111111 : seg_tab[dv];
         e_dp  = (!lit || sup) ? 1'b1 : !m_mask[slot];
         e_fs  = ((t % FRAME) == FRAME - 1);
         if (e_fs) begin
            m_dig  = bus.digits;
            m_mask = bus.dp_mask;
            m_lz   = bus.lz_blank;
         end
         t++;
      end
      @(posedge clk5);
      #1;
      cyc++;
      check_eq("an",          16'(bus.an),          16'(e_an));
      check_eq("seg",         16'(bus.seg),         16'(e_seg));
      check_eq("dp",          16'(bus.dp),          16'(e_dp));
      check_eq("frame_start", 16'(bus.frame_start), 16'(e_fs));
      if (bus.frame_start === 1'b1 && !reset) begin
         if (last_fs >= 0) check_eq("fs_period", 16'(cyc - last_fs), 16'(FRAME));
         last_fs = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      cyc          = 0;
      t            = 0;
      last_fs      = -1;
      reset        = 1'b1;
      bus.digits   = 16'h1234;
      bus.dp_mask  = 4'd0;
      bus.lz_blank = 1'b0;
      bus.blank    = 1'b0;
      run(3);
      reset = 1'b0;
      // Zero snapshot frame, then 1234 frame
      run(2 * FRAME + 4);
      // Anti-tearing: change mid slot 1
      while ((t % FRAME) != DIV + 4) step();
      bus.digits = 16'h9999;
      run(2 * FRAME);
      // Leading-zero suppression
      bus.digits = 16'h0005; bus.lz_blank = 1'b1; bus.dp_mask = 4'd0;
      run(2 * FRAME + 3);
      bus.dp_mask = 4'b0010;
      run(2 * FRAME);
      // Invalid code and live blank
      bus.digits = 16'h00A0; bus.lz_blank = 1'b0; bus.dp_mask = 4'd0;
      run(FRAME + 5);
      bus.blank = 1'b1;
      run(5);
      bus.blank = 1'b0;
      run(FRAME);
      // Reset at cnt=5, idx=2
      while ((t % FRAME) != 2 * DIV + 5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      // Three full frames and then some
      run(3 * FRAME + 8);
      // Random stimulus
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            bus.digits   = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bus.digits = bus.digits & 16'h00FF;
            bus.dp_mask  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) bus.dp_mask = 4'd0;
            bus.lz_blank = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 29) == 0) bus.blank = ~bus.blank;
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
      bus.blank = 1'b0;
      run(FRAME);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
